// File: rtl/button_debouncer.sv
// Synchronises a bouncing button level and qualifies each change over STABLE_TICKS tick samples.
// State encoding puts clean_out and busy directly on the state register bits.
module button_debouncer #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic noisy_in,
    output logic clean_out,
    output logic busy
);

    // bit[1] = clean level, bit[0] = qualification in progress
    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_WAIT = 2'b01,
        HIGH      = 2'b10,
        FALL_WAIT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], noisy_in};
    assign s      = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                LOW: begin
                    if (s) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = HIGH;
                        end else begin
                            state_d = RISE_WAIT;
                            cnt_d   = ONE_CNT;
                        end
                    end
                end
                RISE_WAIT: begin
                    if (!s) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = LOW;
                        end else begin
                            state_d = FALL_WAIT;
                            cnt_d   = ONE_CNT;
                        end
                    end
                end
                FALL_WAIT: begin
                    if (s) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end
            endcase
        end
    end

    assign clean_out = state_q[1];
    assign busy      = state_q[0];

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: default build plus a STABLE_TICKS=1 build on shared inputs.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst, tick, noisy_in;
    logic clean_out, busy;
    logic clean1, busy1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    button_debouncer #(.SYNC_STAGES(2), .STABLE_TICKS(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .tick(tick), .noisy_in(noisy_in),
        .clean_out(clean_out), .busy(busy)
    );

    button_debouncer #(.SYNC_STAGES(2), .STABLE_TICKS(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .noisy_in(noisy_in),
        .clean_out(clean1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; noisy_in = 1'b0; tick = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    logic bounce [1:9];
    logic bexp_busy [1:9];

    initial begin
        rst = 1'b1; tick = 1'b1; noisy_in = 1'b1;
        #1;

        // reset held against active inputs
        step();
        chk("rst_e1_clean", clean_out, 1'b0);
        chk("rst_e1_busy",  busy,      1'b0);
        step();
        chk("rst_e2_clean", clean_out, 1'b0);
        chk("rst_e2_busy",  busy,      1'b0);
        rst = 1'b0;
        step();
        chk("rel_clean", clean_out, 1'b0);
        chk("rel_busy",  busy,      1'b0);

        // clean rise, tick tied high: busy on edges 3..5, clean from edge 6
        do_reset();
        noisy_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("rise_clean_e%0d", k), clean_out, (k >= 6) ? 1'b1 : 1'b0);
            chk($sformatf("rise_busy_e%0d", k),  busy, (k >= 3 && k <= 5) ? 1'b1 : 1'b0);
        end

        // glitch of 3 clk: three qualifying samples, then s drops before the fourth
        do_reset();
        noisy_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) noisy_in = 1'b0;
            step();
            chk($sformatf("glitch_clean_e%0d", k), clean_out, 1'b0);
            chk($sformatf("glitch_busy_e%0d", k),  busy, (k >= 3 && k <= 5) ? 1'b1 : 1'b0);
        end

        // tick-paced fall from HIGH; ticks on edges 10,20,30,40
        do_reset();
        noisy_in = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        chk("fall_pre_clean", clean_out, 1'b1);
        noisy_in = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick = (k % 10 == 0) ? 1'b1 : 1'b0;
            step();
            chk($sformatf("fall_clean_e%0d", k), clean_out, (k < 40) ? 1'b1 : 1'b0);
            chk($sformatf("fall_busy_e%0d", k),  busy, (k >= 10 && k < 40) ? 1'b1 : 1'b0);
        end

        // bounce train, one level per 4-clk tick interval
        bounce    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bexp_busy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int j = 1; j <= 9; j++) begin
            noisy_in = bounce[j];
            for (int e = 1; e <= 4; e++) begin
                tick = (e == 4) ? 1'b1 : 1'b0;
                step();
            end
            chk($sformatf("bounce_clean_t%0d", j), clean_out, (j >= 8) ? 1'b1 : 1'b0);
            chk($sformatf("bounce_busy_t%0d", j),  busy, bexp_busy[j]);
        end

        // reset while RISE_WAIT cnt=2, then a full fresh window is needed
        do_reset();
        noisy_in = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        chk("mid_pre_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        chk("mid_rst_busy",  busy,      1'b0);
        chk("mid_rst_clean", clean_out, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("mid_after_clean_e%0d", k), clean_out, (k >= 6) ? 1'b1 : 1'b0);
        end

        // STABLE_TICKS=1 build: one tick sample switches, busy never rises
        do_reset();
        noisy_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("st1_rise_clean_e%0d", k), clean1, (k >= 3) ? 1'b1 : 1'b0);
            chk($sformatf("st1_rise_busy_e%0d", k),  busy1, 1'b0);
        end
        noisy_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("st1_fall_clean_e%0d", k), clean1, (k >= 3) ? 1'b0 : 1'b1);
            chk($sformatf("st1_fall_busy_e%0d", k),  busy1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditioning stage directly upstream of the rising-edge detector on the board-input path.
- Takes a raw, asynchronous, bouncing push-button or switch level and synchronises it into the clk domain.
- Filters the level with a tick-paced counter FSM and emits one clean level for the edge detector's `signal` input.
- `tick` is the sample-enable strobe from the existing clock divider, so the debounce window scales with the divider.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on noisy_in (legal range 2..4).
- STABLE_TICKS, 4, consecutive tick samples of the new level required before clean_out changes (legal range 1..2^CNT_W-1).
- CNT_W, 3, width of the stability counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk sample strobe; FSM advances only on cycles where tick=1.
- noisy_in  input  1  raw asynchronous button/switch level.
- clean_out  output  1  debounced level; feeds the edge detector's signal input.
- busy  output  1  high while a level change is being qualified.

Behaviour:
- Interface (already decided): single clock, clk. Reset rst is synchronous and active-high.
- Reset, when rst=1 at a clk edge:
  - All synchroniser flops go to 0.
  - state=LOW, cnt=0, clean_out=0, busy=0.
  - rst takes priority over tick and noisy_in.
  - Reset mid-qualification aborts it; there is no residual count.
- Synchroniser:
  - noisy_in shifts through SYNC_STAGES flops every clk, regardless of tick.
  - s = last stage. Only s is used downstream; noisy_in never reaches the FSM directly.
- FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT. On tick=0 cycles, state and cnt hold.
- LOW (clean_out=0), on tick:
  - s=1 and STABLE_TICKS=1 -> HIGH.
  - s=1 otherwise -> RISE_WAIT, cnt=1.
  - s=0 -> stay.
- RISE_WAIT, on tick:
  - s=0 -> LOW, cnt=0 (glitch rejected; clean_out never changed).
  - s=1 and cnt==STABLE_TICKS-1 -> HIGH, cnt=0.
  - s=1 otherwise -> cnt+1.
- HIGH (clean_out=1): mirror of LOW with s=0 -> FALL_WAIT (or -> LOW directly when STABLE_TICKS=1).
- FALL_WAIT: mirror of RISE_WAIT.
  - s=1 -> HIGH, cnt=0.
  - s=0 and cnt==STABLE_TICKS-1 -> LOW.
- clean_out:
  - Registered; equals 1 exactly in state HIGH or FALL_WAIT.
  - Changes only on a tick cycle edge.
- busy: 1 exactly in RISE_WAIT or FALL_WAIT, decoded from the state register (no extra latency).
- Latency, for a clean step on noisy_in:
  - s follows after SYNC_STAGES clk edges.
  - clean_out follows after STABLE_TICKS further ticks that sample the new s.
  - With tick tied high: SYNC_STAGES+STABLE_TICKS clk edges.
- Boundaries:
  - tick tied high is legal; the window becomes STABLE_TICKS clk cycles.
  - Bounce between ticks that is not visible on s at a tick edge is ignored by design.
  - cnt never exceeds STABLE_TICKS-1, so it cannot wrap.
  - No combinational path from any input to any output.

Test Plan:
- Reset check: rst=1 for 2 clk with noisy_in=1 and tick=1 -> clean_out=0, busy=0 during and on the first edge after release.
- Clean rise, tick tied high, defaults:
  - noisy_in 0->1, held.
  - clean_out=1 exactly 6 clk edges later, still 0 at edge 5.
  - busy=1 on edges 3..5.
- Glitch reject, tick tied high:
  - noisy_in=1 for 3 clk, then 0.
  - clean_out stays 0 throughout; busy pulses high then returns to 0 with state LOW.
- Tick-paced fall:
  - Start with clean_out=1, tick every 10th clk; noisy_in 1->0.
  - clean_out=0 on the 4th tick edge at or after s falls; no change on non-tick cycles.
- Bounce train:
  - noisy_in toggles 1,0,1,0,1 on successive ticks, then holds 1.
  - clean_out rises only after 4 consecutive tick samples of 1.
- Reset mid-operation, plus degenerate window:
  - rst asserted while in RISE_WAIT with cnt=2 -> LOW, cnt=0, busy=0 next edge.
  - STABLE_TICKS=1 build: a single tick sampling s=1 sets clean_out and busy never asserts.
